// File: rtl/sw_result_display.sv
// sw_result_display
//   Takes 18-bit alignment scores, converts them to BCD by shift-and-add-3, and drives
//   eight active-low seven-segment digits. Four display modes are available: decimal,
//   hex, accepted-result count, and engine status.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   i_valid    one-cycle strobe, i_result holds a new score
//   i_result   18-bit unsigned score, taken when i_valid && o_ready
//   i_busy     alignment engine busy flag (status mode)
//   i_mode     00 decimal, 01 hex, 10 result count, 11 status
//   o_ready    high when a new i_valid will be accepted
//   o_overrun  sticky, set by i_valid while not ready
//   o_hex0..7  registered active-low segments, bit0 = a ... bit6 = g
module sw_result_display #(
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [17:0] i_result,
    input  logic        i_busy,
    input  logic [1:0]  i_mode,
    output logic        o_ready,
    output logic        o_overrun,
    output logic [6:0]  o_hex0,
    output logic [6:0]  o_hex1,
    output logic [6:0]  o_hex2,
    output logic [6:0]  o_hex3,
    output logic [6:0]  o_hex4,
    output logic [6:0]  o_hex5,
    output logic [6:0]  o_hex6,
    output logic [6:0]  o_hex7
);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegDash  = 7'h3F;
    localparam logic [6:0] SegLowB  = 7'h03;

    typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

    state_e            state_q, state_d;
    logic [17:0]       shift_q, shift_d;
    logic [17:0]       raw_q, raw_d;
    logic [23:0]       bcd_q, bcd_d;
    logic [4:0]        iter_q, iter_d;
    logic [23:0]       disp_bcd_q, disp_bcd_d;
    logic [17:0]       disp_raw_q, disp_raw_d;
    logic [15:0]       count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0][6:0]   hex_q, hex_d;

    logic [23:0]       bcd_adj;
    logic [5:0]        show;
    logic              nz_seen;
    logic [19:0]       raw_pad;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        raw_d      = raw_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        disp_bcd_d = disp_bcd_q;
        disp_raw_d = disp_raw_q;
        count_d    = count_q;
        // A strobe outside IDLE is dropped but remembered until reset.
        overrun_d  = overrun_q | (i_valid & (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_d = i_result;
                    raw_d   = i_result;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d   = {bcd_adj[22:0], shift_q[17]};
                shift_d = {shift_q[16:0], 1'b0};
                iter_d  = iter_q + 5'd1;
                if (iter_q == 5'd17) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                disp_bcd_d = bcd_q;
                disp_raw_d = raw_q;
                count_d    = count_q + 16'd1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Digit i is shown if it or any more significant digit is nonzero; digit 0 always shows.
    always_comb begin
        show    = '0;
        nz_seen = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            nz_seen = nz_seen | (disp_bcd_q[4*i +: 4] != 4'd0);
            show[i] = nz_seen | (i == 0) | (BLANK_LZ == 0);
        end
    end

    assign raw_pad = {2'b00, disp_raw_q};

    always_comb begin
        hex_d = {8{SegBlank}};
        case (i_mode)
            2'b00: begin
                for (int i = 0; i < 6; i++) begin
                    if (show[i]) begin
                        hex_d[i] = seg7(disp_bcd_q[4*i +: 4]);
                    end
                end
            end
            2'b01: begin
                for (int i = 0; i < 5; i++) begin
                    hex_d[i] = seg7(raw_pad[4*i +: 4]);
                end
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    hex_d[i] = seg7(count_q[4*i +: 4]);
                end
            end
            default: begin
                hex_d[0] = i_busy ? SegLowB : SegDash;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            raw_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_bcd_q <= '0;
            disp_raw_q <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            hex_q      <= {8{SegBlank}};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            raw_q      <= raw_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            disp_bcd_q <= disp_bcd_d;
            disp_raw_q <= disp_raw_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            hex_q      <= hex_d;
        end
    end

    assign o_ready   = (state_q == StIdle);
    assign o_overrun = overrun_q;
    assign o_hex0    = hex_q[0];
    assign o_hex1    = hex_q[1];
    assign o_hex2    = hex_q[2];
    assign o_hex3    = hex_q[3];
    assign o_hex4    = hex_q[4];
    assign o_hex5    = hex_q[5];
    assign o_hex6    = hex_q[6];
    assign o_hex7    = hex_q[7];

endmodule

// File: tb/tb_sw_result_display.sv
// tb_sw_result_display
//   Directed and randomized checks of sw_result_display against a reference model that
//   derives expected segments from the score value by plain arithmetic.
module tb_sw_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [17:0] i_result = '0;
    logic        i_busy = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    wire         o_ready;
    wire         o_overrun;
    wire  [6:0]  hx [8];

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int m_val = 0;
    int m_cnt = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sw_result_display #(.BLANK_LZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_result (i_result),
        .i_busy   (i_busy),
        .i_mode   (i_mode),
        .o_ready  (o_ready),
        .o_overrun(o_overrun),
        .o_hex0   (hx[0]),
        .o_hex1   (hx[1]),
        .o_hex2   (hx[2]),
        .o_hex3   (hx[3]),
        .o_hex4   (hx[4]),
        .o_hex5   (hx[5]),
        .o_hex6   (hx[6]),
        .o_hex7   (hx[7])
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_digit(input int idx);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        case (i_mode)
            2'b00: begin
                if (idx > 5) return 7'h7F;
                if (idx > 0 && m_val < p) return 7'h7F;
                return seg_tbl[(m_val / p) % 10];
            end
            2'b01: begin
                if (idx > 4) return 7'h7F;
                return seg_tbl[(m_val >> (4 * idx)) & 15];
            end
            2'b10: begin
                if (idx > 3) return 7'h7F;
                return seg_tbl[(m_cnt >> (4 * idx)) & 15];
            end
            default: begin
                if (idx != 0) return 7'h7F;
                return i_busy ? 7'h03 : 7'h3F;
            end
        endcase
    endfunction

    task automatic check_hex(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s hex%0d", tag, i), 32'(hx[i]), 32'(exp_digit(i)));
        end
    endtask

    task automatic check_blank(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s hex%0d", tag, i), 32'(hx[i]), 32'h7F);
        end
    endtask

    // Accept a value: o_ready must be high, strobe across edge T.
    task automatic start(input int val);
        chk("ready_before_valid", 32'(o_ready), 32'd1);
        i_valid  = 1'b1;
        i_result = 18'(val);
        tick();
        i_valid  = 1'b0;
    endtask

    // Wait for ready (cycles since edge T given by already), then one more edge for o_hex.
    task automatic finish_conv(input int val, input int already, input string tag);
        int n;
        n = already;
        while (o_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd19);
        m_val = val;
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        tick();
        check_hex(tag);
    endtask

    task automatic run(input int val, input string tag);
        start(val);
        finish_conv(val, 0, tag);
    endtask

    initial begin
        int v;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check_blank("reset");
        chk("reset ready", 32'(o_ready), 32'd1);
        chk("reset overrun", 32'(o_overrun), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_hex("idle zero");

        // Decimal 12345
        i_mode = 2'b00;
        run(12345, "dec 12345");
        chk("dec 12345 h4", 32'(hx[4]), 32'h79);
        chk("dec 12345 h0", 32'(hx[0]), 32'h12);
        chk("dec 12345 h5", 32'(hx[5]), 32'h7F);

        // Zero shows a single digit
        run(0, "dec 0");
        chk("dec 0 h0", 32'(hx[0]), 32'h40);

        // Max value, hex then decimal
        i_mode = 2'b01;
        run(262143, "hex max");
        chk("hex max h4", 32'(hx[4]), 32'h30);
        i_mode = 2'b00;
        tick();
        check_hex("dec max");
        chk("dec max h5", 32'(hx[5]), 32'h24);

        // Randomized values and modes
        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, 262143)) >> $urandom_range(0, 17);
            i_mode = 2'($urandom_range(0, 3));
            i_busy = 1'($urandom_range(0, 1));
            run(v, $sformatf("rand%0d", r));
            i_mode = 2'($urandom_range(0, 3));
            i_busy = 1'($urandom_range(0, 1));
            tick();
            check_hex($sformatf("rand%0d remode", r));
        end

        // Count and status modes
        i_mode = 2'b10;
        tick();
        check_hex("count");
        i_mode = 2'b11;
        i_busy = 1'b1;
        tick();
        check_hex("status busy");
        chk("status busy h0", 32'(hx[0]), 32'h03);
        i_busy = 1'b0;
        tick();
        check_hex("status idle");

        // Overrun: second strobe five cycles later is dropped
        i_mode = 2'b00;
        chk("overrun clear", 32'(o_overrun), 32'd0);
        start(100);
        for (int k = 0; k < 4; k++) tick();
        i_valid  = 1'b1;
        i_result = 18'd200;
        tick();
        i_valid  = 1'b0;
        chk("overrun set", 32'(o_overrun), 32'd1);
        finish_conv(100, 5, "overrun dec");
        chk("overrun h2", 32'(hx[2]), 32'h79);
        chk("overrun sticky", 32'(o_overrun), 32'd1);
        i_mode = 2'b10;
        tick();
        check_hex("overrun count");

        // Reset during conversion
        i_mode = 2'b00;
        start(999);
        for (int k = 0; k < 9; k++) tick();
        #2 rst = 1'b1;
        #1;
        check_blank("midop reset");
        chk("midop ready", 32'(o_ready), 32'd1);
        chk("midop overrun", 32'(o_overrun), 32'd0);
        m_val = 0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_hex("after reset");
        run(7, "after reset 7");
        chk("after reset h0", 32'(hx[0]), 32'h78);
        i_mode = 2'b10;
        tick();
        check_hex("after reset count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sw_result_display.md
SW_RESULT_DISPLAY -- requirements
Module: sw_result_display

Interface
REQ-001 Parameter BLANK_LZ, default 1, meaning: 1 blanks leading zeros in decimal mode, 0 shows all six decimal digits.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  one-cycle strobe; i_result holds a new alignment score.
REQ-005 i_result  input  18  unsigned score, sampled when i_valid=1 and o_ready=1.
REQ-006 i_busy  input  1  busy flag from the alignment engine.
REQ-007 i_mode  input  2  display select: 00 decimal, 01 hex, 10 result count, 11 status.
REQ-008 o_ready  output  1  high when a new i_valid will be accepted.
REQ-009 o_overrun  output  1  sticky; set when i_valid arrives while o_ready=0.
REQ-010 o_hex0..o_hex7  output  7 each  registered active-low segments, bit0=a ... bit6=g.

Function
REQ-011 FSM states: IDLE, CONV, UPDATE; o_ready=1 only in IDLE.
REQ-012 IDLE + i_valid: latch i_result into shift register, clear 24-bit BCD register and 5-bit iteration counter, go to CONV.
REQ-013 CONV: per cycle, add 3 to each BCD nibble >=5, then shift {BCD,shift} left 1; exactly 18 cycles, then UPDATE.
REQ-014 UPDATE (one cycle): copy BCD to display-BCD register, copy latched raw value to display-raw register, increment 16-bit count (65535 wraps to 0), go to IDLE.
REQ-015 Latency: i_valid accepted at edge T -> display registers updated at edge T+19 -> o_hex reflects it at edge T+20; o_ready high again after edge T+19.
REQ-016 i_valid while o_ready=0: input dropped, o_overrun set to 1 and held until rst; conversion in progress unaffected.
REQ-017 o_hex registered from (display-BCD, display-raw, count, i_mode, i_busy); i_mode change visible one cycle later.
REQ-018 Mode 00: HEX5..HEX0 = six BCD digits (HEX0 least significant); HEX7,HEX6 blank; BLANK_LZ=1 blanks digits above the most significant nonzero digit; value 0 shows '0' on HEX0 only.
REQ-019 Mode 01: HEX4..HEX0 = display-raw as hex (HEX4 holds bits 17:16, range 0-3); HEX7..HEX5 blank; no leading-zero blanking.
REQ-020 Mode 10: HEX3..HEX0 = count in hex, zeros shown; HEX7..HEX4 blank.
REQ-021 Mode 11: HEX0 = 'b' when i_busy=1, '-' when i_busy=0; HEX7..HEX1 blank.
REQ-022 Encoding: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E '-'=3F blank=7F (hex).
REQ-023 Max input 262143 converts without overflow (6 BCD digits suffice); BCD nibbles never exceed 9 after conversion.

Reset
REQ-024 rst=1 forces immediately, independent of clk: state IDLE, o_ready=1, o_overrun=0, all o_hex=7F, BCD/raw/display/count registers 0.
REQ-025 rst during CONV or UPDATE: conversion abandoned, no display update, no count increment.
REQ-026 After rst deasserts, first i_valid is accepted on the next rising edge.

Verification
REQ-027 Reset: assert rst -> all o_hex=7F, o_ready=1, o_overrun=0 with no clock edge needed.
REQ-028 Decimal: mode 00, i_valid with 12345 -> o_ready low 19 cycles; at T+20 HEX4..0=79,24,30,19,12, HEX7..5=7F; value 0 -> HEX0=40, others 7F.
REQ-029 Hex: mode 01, i_valid with 262143 -> HEX4..0=30,0E,0E,0E,0E, HEX7..5=7F; switch to mode 00 -> HEX5..0=24,02,24,79,19,30.
REQ-030 Overrun: i_valid 100, then i_valid 200 five cycles later -> o_overrun=1, decimal display shows 100 (HEX2..0=79,40,40), count=1.
REQ-031 Count/status: three accepted results, mode 10 -> HEX3..0=40,40,40,30; mode 11 with i_busy=1 -> HEX0=03, i_busy=0 -> HEX0=3F.
REQ-032 Reset mid-op: accept 999 in mode 00, assert rst at 10th CONV cycle -> outputs 7F, count 0; after release, i_valid 7 -> HEX0=78 at T+20.
